// File: rtl/ic_tester_pkg.sv
// ic_tester_pkg: frame constants and serialiser state encoding shared by the result transmitter.
package ic_tester_pkg;
  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int FRAME_LEN = 11;
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_e;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser; ready in the last stop cycle lets bytes run back-to-back.
module uart_tx_byte
  import ic_tester_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic tick;
  assign tick = cnt_q == LAST;
  // LOAD is the first cycle of the start bit, so the baud counter already runs there
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    ready_o = state_q == IDLE || (state_q == STOP && tick);
    tx_o = !(state_q == LOAD || state_q == START) && (state_q != DATA || sh_q[0]);
    case (state_q)
      LOAD: state_d = START;
      START: state_d = tick ? DATA : START;
      DATA: if (tick) begin
        sh_d = sh_q >> 1;
        bit_d = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      default: ;
    endcase
    if (ready_o) begin
      state_d = valid_i ? LOAD : IDLE;
      sh_d = valid_i ? data_i : sh_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
    end
  end
endmodule

// File: rtl/result_uart_tx.sv
// result_uart_tx: captures one test result and sends it as an 11-byte UART frame with XOR checksum.
module result_uart_tx
  import ic_tester_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int VEC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic             pass_in,
  input  logic             fail_in,
  input  logic [VEC_W-1:0] exp_vec,
  input  logic [VEC_W-1:0] got_vec,
  output logic             busy,
  output logic             done,
  output logic             tx
);
  logic active_q, active_d, done_q, done_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] meta_q, meta_d;
  logic [VEC_W-1:0] exp_q, exp_d, got_q, got_d;
  logic [7:0] frame [16];
  logic accept, valid, ready, fin;
  always_comb begin
    frame = '{default: 8'h00};
    frame[0] = FRAME_HDR;
    frame[1] = meta_q;
    for (int i = 0; i < 4; i++) begin
      frame[2+i] = exp_q[8*i +: 8];
      frame[6+i] = got_q[8*i +: 8];
    end
    for (int i = 0; i < 10; i++) frame[10] = frame[10] ^ frame[i];
  end
  // idx is 0 while idle, so the header is offered in the very cycle start is accepted
  assign accept = start && !active_q && !done_q;
  assign valid = accept || (active_q && idx_q < 4'(FRAME_LEN));
  assign fin = active_q && idx_q == 4'(FRAME_LEN) && ready;
  always_comb begin
    active_d = accept || (active_q && !fin);
    done_d = fin;
    idx_d = fin ? '0 : (valid && ready) ? idx_q + 4'd1 : idx_q;
    meta_d = accept ? {pass_in, fail_in, 3'b000, gate_sel} : meta_q;
    exp_d = accept ? exp_vec : exp_q;
    got_d = accept ? got_vec : got_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      done_q <= 1'b0;
      idx_q <= '0;
      meta_q <= '0;
      exp_q <= '0;
      got_q <= '0;
    end else begin
      active_q <= active_d;
      done_q <= done_d;
      idx_q <= idx_d;
      meta_q <= meta_d;
      exp_q <= exp_d;
      got_q <= got_d;
    end
  end
  assign busy = active_q;
  assign done = done_q;
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk),
    .rst_n(rst_n),
    .valid_i(valid),
    .data_i(frame[idx_q]),
    .ready_o(ready),
    .tx_o(tx)
  );
endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: scoreboard bench; a UART monitor decodes tx and checks bytes and byte spacing.
module tb_result_uart_tx;
  localparam int CPB = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pass_in = 1'b0, fail_in = 1'b0;
  logic [2:0] gate_sel = '0;
  logic [31:0] exp_vec = '0, got_vec = '0;
  logic busy, done, tx;
  int checks = 0, errors = 0, cyc = 0, bc = 0, dc = 0;
  typedef struct {logic [7:0] b; int gap;} exp_t;
  exp_t q[$];
  logic [7:0] basic [11] = '{8'hA5, 8'h82, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h27};

  result_uart_tx #(.CLKS_PER_BIT(CPB), .VEC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_sel(gate_sel), .pass_in(pass_in),
    .fail_in(fail_in), .exp_vec(exp_vec), .got_vec(got_vec), .busy(busy), .done(done), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy) bc <= bc + 1;
    if (done) dc <= dc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic void push_frame(input logic [2:0] g, input logic p, input logic f,
                                     input logic [31:0] e, input logic [31:0] o, input int gap0, input int n);
    logic [7:0] b [11];
    b[0] = 8'hA5;
    b[1] = {p, f, 3'b000, g};
    for (int i = 0; i < 4; i++) begin
      b[2+i] = e[8*i +: 8];
      b[6+i] = o[8*i +: 8];
    end
    b[10] = 8'h00;
    for (int i = 0; i < 10; i++) b[10] = b[10] ^ b[i];
    for (int i = 0; i < n; i++) q.push_back('{b[i], i == 0 ? gap0 : 40});
  endfunction

  task automatic set_in(input logic [2:0] g, input logic p, input logic f, input logic [31:0] e, input logic [31:0] o);
    gate_sel = g; pass_in = p; fail_in = f; exp_vec = e; got_vec = o;
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // UART monitor: bit j of a byte is sampled mid-bit; a byte disturbed by reset is dropped
  initial begin
    int last = 0, t0;
    logic [7:0] b;
    logic ab, stp;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        t0 = cyc;
        ab = 1'b0;
        for (int j = 0; j < 8; j++) begin
          repeat (j == 0 ? 6 : 4) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
          b[j] = tx;
        end
        repeat (4) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
        stp = tx;
        @(negedge clk);
        if (!rst_n) ab = 1'b1;
        if (!ab) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %h expected none", b);
          end else begin
            e = q.pop_front();
            chk("byte", {24'h0, b}, {24'h0, e.b});
            chk("stop_bit", {31'h0, stp}, 32'h1);
            if (e.gap > 0) chk("byte_spacing", t0 - last, e.gap);
          end
          last = t0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int bad, b0, d0, n;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("reset_idle", bad, 0);

    set_in(3'b010, 1'b1, 1'b0, 32'h0000FFFF, 32'h0000FFFF);
    foreach (basic[i]) q.push_back('{basic[i], i == 0 ? 0 : 40});
    b0 = bc; d0 = dc;
    pulse_start;
    repeat (500) @(negedge clk);
    chk("basic_busy_len", bc - b0, 440);
    chk("basic_done_cnt", dc - d0, 1);
    chk("basic_queue", q.size(), 0);

    set_in(3'b101, 1'b0, 1'b1, 32'h12345678, 32'h12345679);
    push_frame(3'b101, 1'b0, 1'b1, 32'h12345678, 32'h12345679, 0, 11);
    b0 = bc; d0 = dc;
    pulse_start;
    repeat (500) @(negedge clk);
    chk("fail_busy_len", bc - b0, 440);
    chk("fail_done_cnt", dc - d0, 1);

    set_in(3'b111, 1'b1, 1'b1, 32'hDEADBEEF, 32'h01020304);
    push_frame(3'b111, 1'b1, 1'b1, 32'hDEADBEEF, 32'h01020304, 0, 11);
    b0 = bc; d0 = dc;
    pulse_start;
    repeat (100) @(negedge clk);
    set_in(3'b000, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF);
    pulse_start;
    repeat (700) @(negedge clk);
    chk("ignored_busy_len", bc - b0, 440);
    chk("ignored_done_cnt", dc - d0, 1);

    push_frame(3'b011, 1'b1, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 11);
    push_frame(3'b100, 1'b0, 1'b0, 32'h80000001, 32'h7FFFFFFE, 42, 11);
    set_in(3'b011, 1'b1, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D);
    d0 = dc;
    pulse_start;
    set_in(3'b100, 1'b0, 1'b0, 32'h80000001, 32'h7FFFFFFE);
    n = 0;
    while (done !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    chk("b2b_done_seen", {31'h0, done}, 32'h1);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (500) @(negedge clk);
    chk("b2b_done_cnt", dc - d0, 2);

    set_in(3'b001, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A);
    push_frame(3'b001, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 5);
    pulse_start;
    repeat (220) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("rst_partial_queue", q.size(), 0);
    chk("rst_tx_idle", {31'h0, tx}, 32'h1);
    push_frame(3'b110, 1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFF, 0, 11);
    set_in(3'b110, 1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFF);
    b0 = bc; d0 = dc;
    pulse_start;
    repeat (500) @(negedge clk);
    chk("fresh_busy_len", bc - b0, 440);
    chk("fresh_done_cnt", dc - d0, 1);
    chk("final_queue", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
